xdma_master: RTL and testbench
==============================

// Module: xdma_master
// PURPOSE
//  Bus initiator for the picoversat data bus: copies a block of LEN 32-bit words
//  from SRC to DST by issuing read then write transactions through the address
//  decoder, exactly as the controller does. Requests the bus via req/gnt
//  arbitration with the controller; sits beside the controller on the bus master side.
// PARAMETERS
//  READ_LAT  1   cycles from a read request (sel=1,we=0) to data_to_rd valid; legal 0..3
//  LEN_W     16  width of word-count register
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, active-high
//  start       in   1        one-cycle pulse: latch src/dst/len and begin copy
//  src         in   ADDR_W   source base word address
//  dst         in   ADDR_W   destination base word address
//  len         in   LEN_W    number of words to copy
//  busy        out  1        high from cycle after accepted start until done
//  done        out  1        one-cycle pulse when copy completes
//  req         out  1        bus request to arbiter
//  gnt         in   1        bus grant; bus ports may drive only while gnt=1
//  addr        out  ADDR_W   bus address
//  sel         out  1        bus select (decoder global select)
//  we          out  1        1=write, 0=read
//  data_to_wr  out  DATA_W   write data
//  data_to_rd  in   DATA_W   read data returned by decoder mux
// BEHAVIOUR
//  Reset: state=IDLE; busy,done,req,sel,we=0; addr,data_to_wr=0; counters=0.
//  States: IDLE, REQ, RD, WAIT, WR, DONE.
//  IDLE: start=1 & len!=0 -> latch src/dst/len, idx=0, go REQ; busy=1 next cycle.
//        start=1 & len==0 -> go DONE (no bus activity). start ignored outside IDLE.
//  REQ:  req=1; gnt=1 -> RD.
//  RD:   req=1; if gnt: sel=1,we=0,addr=src+idx; -> WAIT (READ_LAT=0: -> WR, data
//        captured this cycle). if !gnt: sel=0, stay.
//  WAIT: req=1, sel=0; count READ_LAT cycles; capture data_to_rd into wbuf in the
//        cycle the count reaches READ_LAT (i.e. READ_LAT cycles after RD), -> WR.
//        Count proceeds regardless of gnt.
//  WR:   req=1; if gnt: sel=1,we=1,addr=dst+idx,data_to_wr=wbuf; idx+=1;
//        idx+1==len_latched -> DONE else -> RD. if !gnt: sel=0, stay.
//  DONE: done=1 for exactly one cycle, req=0, busy=0 -> IDLE.
//  req is high in REQ/RD/WAIT/WR only; drops in DONE.
//  sel never asserted without gnt in the same cycle; addr/we/data_to_wr=0 when sel=0.
//  Address arithmetic modulo 2^ADDR_W (wraps silently); idx is LEN_W bits.
//  Per word with gnt held: 2+READ_LAT cycles; done pulse cycle after final WR.
//  Overlapping src/dst ranges: copy proceeds ascending, no hazard detection.
//  rst mid-transfer: abort immediately to reset values; no done pulse.
// TESTING
//  1) len=4,src=0x10,dst=0x40,gnt=1,READ_LAT=1: reads 0x10..0x13, writes 0x40..0x43
//     with read data; done pulses 12 cycles after first RD; busy=0 after.
//  2) len=0 start: done pulses next cycle, req/sel never high.
//  3) gnt low 5 cycles during REQ then toggled during WR: sel only while gnt=1,
//     data/addresses unchanged, total words written=len.
//  4) src=2^ADDR_W-1,len=2: second read address wraps to 0.
//  5) start pulsed while busy with different src: ignored, original copy completes.
//  6) rst asserted during WAIT of word 2: next cycle all outputs 0, state IDLE,
//     no done; new start afterwards copies correctly.

Source files
------------

// File: rtl/xdma_master.sv
// xdma_master -- block-copy bus initiator for the picoversat data bus.
//
// Copies len 32-bit words from src to dst, one word at a time: read through the
// address decoder, hold the word in wbuf, then write it back out. The bus is
// shared with the controller, so every transaction waits on req/gnt.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, src/dst/len  one-cycle copy command, latched in IDLE only
//   busy, done          copy in progress / one-cycle completion pulse
//   req, gnt            arbiter handshake
//   addr, sel, we,
//   data_to_wr          bus strobe (all zero whenever sel=0)
//   data_to_rd          read data from the decoder mux, READ_LAT cycles after
//                       the read strobe
module xdma_master #(
  parameter int READ_LAT = 1,   // 0..3
  parameter int LEN_W    = 16,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              req,
  input  logic              gnt,
  output logic [ADDR_W-1:0] addr,
  output logic              sel,
  output logic              we,
  output logic [DATA_W-1:0] data_to_wr,
  input  logic [DATA_W-1:0] data_to_rd
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD, S_WAIT, S_WR, S_DONE
  } state_t;

  localparam logic [1:0] LAT = 2'(READ_LAT);

  state_t              state;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [LEN_W-1:0]    len_q, idx;
  logic [1:0]          lat_cnt;
  logic [DATA_W-1:0]   wbuf;
  logic [ADDR_W-1:0]   idx_a;

  // idx is LEN_W wide; address sums wrap modulo 2^ADDR_W.
  assign idx_a = ADDR_W'(idx);

  // Status outputs are pure decodes of the state register.
  assign req  = (state == S_REQ) || (state == S_RD) || (state == S_WAIT) || (state == S_WR);
  assign busy = req;
  assign done = (state == S_DONE);

  // The strobe has to follow gnt within the same cycle, so it is combinational
  // on gnt; everything else on the bus is forced to zero when not selected.
  assign sel        = gnt && ((state == S_RD) || (state == S_WR));
  assign we         = gnt && (state == S_WR);
  assign addr       = !sel ? '0 : (we ? dst_q + idx_a : src_q + idx_a);
  assign data_to_wr = we ? wbuf : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx     <= '0;
      lat_cnt <= '0;
      wbuf    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              src_q <= src;
              dst_q <= dst;
              len_q <= len;
              idx   <= '0;
              state <= S_REQ;
            end else begin
              state <= S_DONE;     // empty copy: pulse done, never touch the bus
            end
          end
        end
        S_REQ: if (gnt) state <= S_RD;
        S_RD: begin
          if (gnt) begin
            if (LAT == 2'd0) begin
              wbuf  <= data_to_rd; // zero-latency decoder: data valid now
              state <= S_WR;
            end else begin
              lat_cnt <= 2'd1;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Counts regardless of gnt: the decoder returns data on its own clock.
          if (lat_cnt == LAT) begin
            wbuf  <= data_to_rd;
            state <= S_WR;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_WR: begin
          if (gnt) begin
            idx <= idx + LEN_W'(1);
            if ((idx + LEN_W'(1)) == len_q) state <= S_DONE;
            else                            state <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xdma_master.sv
module tb_xdma_master;
  localparam int ADDR_W = 8, DATA_W = 32, LEN_W = 16, READ_LAT = 1;

  logic              clk = 1'b0;
  logic              rst, start, gnt;
  logic [ADDR_W-1:0] src, dst, addr;
  logic [LEN_W-1:0]  len;
  logic              busy, done, req, sel, we;
  logic [DATA_W-1:0] data_to_wr, data_to_rd;

  xdma_master #(.READ_LAT(READ_LAT), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .req(req), .gnt(gnt), .addr(addr), .sel(sel),
    .we(we), .data_to_wr(data_to_wr), .data_to_rd(data_to_rd)
  );

  always #5 clk = ~clk;

  // Decoder/memory model: each address reads back a fixed pattern, 1-cycle latency.
  function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] a);
    return {8'h5A, a, ~a, 8'h3C};
  endfunction

  always @(posedge clk) if (sel && !we) data_to_rd <= rd_fn(addr);

  typedef struct {
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0]  len;
    bit                mode;     // 0: gnt held, 1: gnt low 5 cycles then toggling
    bit                inject;   // pulse a second start mid-copy
    int                exp_cyc;  // cycles from start to done, -1 = don't care
    bit                exp_req;
  } vec_t;

  int n_tests = 0, n_fail = 0;
  logic [ADDR_W-1:0] rd_q[$];
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  bit done_seen, req_seen, sel_bad, bus_bad;
  logic l_busy, l_done, l_req, l_sel, l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample/score outputs at negedge, return 1ns after posedge.
  task automatic tick();
    @(negedge clk);
    l_busy = busy; l_done = done; l_req = req; l_sel = sel; l_we = we;
    l_addr = addr; l_wr = data_to_wr;
    if (sel && !gnt) sel_bad = 1;
    if (!sel && (addr != '0 || we || data_to_wr != '0)) bus_bad = 1;
    if (req)  req_seen = 1;
    if (done) done_seen = 1;
    if (sel && !we) begin
      if (rd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rd_unexpected: got addr %0h expected no read", addr);
      end else check("rd_addr", 64'(addr), 64'(rd_q.pop_front()));
    end
    if (sel && we) begin
      if (wa_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wr_unexpected: got addr %0h expected no write", addr);
      end else begin
        check("wr_addr", 64'(addr), 64'(wa_q.pop_front()));
        check("wr_data", 64'(data_to_wr), 64'(wd_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                             input logic [LEN_W-1:0] n);
    for (int i = 0; i < int'(n); i++) begin
      rd_q.push_back(s + ADDR_W'(i));
      wa_q.push_back(d + ADDR_W'(i));
      wd_q.push_back(rd_fn(s + ADDR_W'(i)));
    end
  endtask

  task automatic run_copy(input vec_t v);
    int  c, done_cyc;
    bit  busy_bad;
    done_seen = 0; req_seen = 0; sel_bad = 0; bus_bad = 0; busy_bad = 0;
    done_cyc = -1;
    push_expect(v.src, v.dst, v.len);
    src = v.src; dst = v.dst; len = v.len; start = 1; gnt = 1;
    tick();
    start = 0;
    c = 1;
    while (!done_seen && c < 300) begin
      if (v.mode) gnt = (c <= 5) ? 1'b0 : c[0];
      else        gnt = 1'b1;
      if (v.inject && c == 4) begin
        start = 1; src = 8'h80; len = 16'd7;
      end else start = 0;
      tick();
      if (done_seen) done_cyc = c;
      else if (l_busy !== (v.len != 0)) busy_bad = 1;
      c++;
    end
    start = 0;
    if (v.exp_cyc >= 0) check("done_cycle", 64'(done_cyc), 64'(v.exp_cyc));
    else                check("done_seen", 64'(done_seen), 64'd1);
    check("reads_left", 64'(rd_q.size()), 64'd0);
    check("writes_left", 64'(wa_q.size()), 64'd0);
    check("req_seen", 64'(req_seen), 64'(v.exp_req));
    check("sel_without_gnt", 64'(sel_bad), 64'd0);
    check("bus_idle_nonzero", 64'(bus_bad), 64'd0);
    check("busy_during", 64'(busy_bad), 64'd0);
    gnt = 1;
    tick();
    check("done_one_cycle", 64'(l_done), 64'd0);
    check("busy_after", 64'(l_busy), 64'd0);
    check("req_after", 64'(l_req), 64'd0);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 64'(l_busy), 64'd0);
    check({name, "_done"}, 64'(l_done), 64'd0);
    check({name, "_req"},  64'(l_req),  64'd0);
    check({name, "_sel"},  64'(l_sel),  64'd0);
    check({name, "_bus"},  64'({l_we, l_addr, l_wr}), 64'd0);
  endtask

  vec_t vecs[6];
  vec_t post;

  initial begin
    vecs[0] = '{8'h10, 8'h40, 16'd4, 1'b0, 1'b0, 14, 1'b1};  // basic copy
    vecs[1] = '{8'h00, 8'h20, 16'd0, 1'b0, 1'b0,  1, 1'b0};  // empty copy
    vecs[2] = '{8'h30, 8'h50, 16'd3, 1'b1, 1'b0, -1, 1'b1};  // gnt stalls
    vecs[3] = '{8'hFF, 8'h60, 16'd2, 1'b0, 1'b0,  8, 1'b1};  // src wraps
    vecs[4] = '{8'h05, 8'h07, 16'd5, 1'b0, 1'b1, 17, 1'b1};  // overlap + ignored start
    vecs[5] = '{8'h70, 8'hFE, 16'd3, 1'b0, 1'b0, 11, 1'b1};  // dst wraps

    rst = 1; start = 0; gnt = 0; src = '0; dst = '0; len = '0;
    sel_bad = 0; bus_bad = 0;
    repeat (3) tick();
    rst = 0;
    tick();
    check_all_zero("reset");

    foreach (vecs[i]) run_copy(vecs[i]);

    // Reset during WAIT of the second word: abort, no done, bus quiet.
    done_seen = 0;
    push_expect(8'h20, 8'h90, 16'd2);   // only words reached before the abort
    wa_q.pop_back(); wd_q.pop_back();   // second word's write never happens
    src = 8'h20; dst = 8'h90; len = 16'd4; start = 1; gnt = 1;
    tick();                              // cycle 0: start accepted
    start = 0;
    repeat (5) tick();                   // REQ, RD0, WAIT0, WR0, RD1
    rst = 1;
    tick();                              // WAIT1, reset sampled at its end
    rst = 0;
    tick();
    check_all_zero("abort");
    check("abort_reads_left", 64'(rd_q.size()), 64'd0);
    check("abort_writes_left", 64'(wa_q.size()), 64'd0);
    req_seen = 0;
    repeat (20) tick();
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_no_req", 64'(req_seen), 64'd0);

    post = '{8'h31, 8'hA0, 16'd3, 1'b0, 1'b0, 11, 1'b1};
    run_copy(post);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
